// File: rtl/icache_refill_ctrl.sv
// Direct-mapped read-only instruction cache controller over tag/data macros with line refill.
// Optional ICACHE_STATS_EN adds hit_count/miss_count output ports.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 2,
  localparam int unsigned TAG_BITS   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2
) (
  input  logic                              clka,
  input  logic                              rsta_n,
  input  logic                              cpu_req_valid,
  output logic                              cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]             cpu_req_addr,
  output logic                              cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0]             cpu_rsp_data,
  input  logic                              flush,
  output logic                              tag_ena,
  output logic                              tag_wea,
  output logic [INDEX_BITS-1:0]             tag_addr,
  output logic [TAG_BITS-1:0]               tag_din,
  input  logic [TAG_BITS-1:0]               tag_dout,
  output logic                              data_ena,
  output logic                              data_wea,
  output logic [INDEX_BITS+OFFSET_BITS-1:0] data_addr,
  output logic [DATA_WIDTH-1:0]             data_din,
  input  logic [DATA_WIDTH-1:0]             data_dout,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  input  logic                              mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_rsp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                       hit_count,
  output logic [31:0]                       miss_count
`endif
);

  localparam int unsigned LINES = 2 ** INDEX_BITS;
  localparam int unsigned AW    = ADDR_WIDTH - 2;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOOKUP   = 3'd1;
  localparam logic [2:0] MISS_REQ = 3'd2;
  localparam logic [2:0] REFILL   = 3'd3;
  localparam logic [2:0] RESPOND  = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [DATA_WIDTH-1:0]  crit_q, crit_d;

  logic [INDEX_BITS-1:0]  req_idx, cur_idx;
  logic [OFFSET_BITS-1:0] req_word, cur_word;
  logic [TAG_BITS-1:0]    cur_tag;
  logic                   hit;
  logic                   unused_addr_lsb;

  // Word-address view of the request; byte-lane bits are not used.
  assign unused_addr_lsb = ^cpu_req_addr[1:0];
  assign req_idx  = cpu_req_addr[2+OFFSET_BITS +: INDEX_BITS];
  assign req_word = cpu_req_addr[2 +: OFFSET_BITS];
  assign cur_tag  = addr_q[AW-1 -: TAG_BITS];
  assign cur_idx  = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign cur_word = addr_q[0 +: OFFSET_BITS];
  assign hit      = valid_q[cur_idx] && (tag_dout == cur_tag);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    valid_d       = valid_q;
    cnt_d         = cnt_q;
    flush_pend_d  = flush_pend_q;
    crit_d        = crit_q;
    cpu_req_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    cpu_rsp_data  = '0;
    tag_ena       = 1'b0;
    tag_wea       = 1'b0;
    tag_addr      = '0;
    tag_din       = '0;
    data_ena      = 1'b0;
    data_wea      = 1'b0;
    data_addr     = '0;
    data_din      = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;

    case (state_q)
      IDLE: begin
        if (flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else begin
          cpu_req_ready = 1'b1;
          if (cpu_req_valid) begin
            addr_d    = cpu_req_addr[ADDR_WIDTH-1:2];
            tag_ena   = 1'b1;
            data_ena  = 1'b1;
            tag_addr  = req_idx;
            data_addr = {req_idx, req_word};
            state_d   = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (hit) begin
          cpu_rsp_valid = 1'b1;
          cpu_rsp_data  = data_dout;
          state_d       = IDLE;
        end else begin
          valid_d[cur_idx] = 1'b0;
          state_d          = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {cur_tag, cur_idx, {(OFFSET_BITS + 2){1'b0}}};
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_rsp_valid) begin
          data_ena  = 1'b1;
          data_wea  = 1'b1;
          data_addr = {cur_idx, cnt_q};
          data_din  = mem_rsp_data;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == cur_word) crit_d = mem_rsp_data;
          if (cnt_q == {OFFSET_BITS{1'b1}}) begin
            tag_ena          = 1'b1;
            tag_wea          = 1'b1;
            tag_addr         = cur_idx;
            tag_din          = cur_tag;
            valid_d[cur_idx] = 1'b1;
            state_d          = RESPOND;
          end
        end
      end
      RESPOND: begin
        cpu_rsp_valid = 1'b1;
        cpu_rsp_data  = crit_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outside IDLE a flush is deferred so an in-flight refill still completes.
    if (flush && (state_q != IDLE)) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      crit_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      crit_q       <= crit_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl with behavioural tag/data macros and a scripted memory.
module tb_icache_refill_ctrl;

  logic        clka = 1'b0;
  logic        rsta_n;
  logic        cpu_req_valid, cpu_req_ready;
  logic [31:0] cpu_req_addr;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_data;
  logic        flush;
  logic        tag_ena, tag_wea;
  logic [5:0]  tag_addr;
  logic [21:0] tag_din, tag_dout;
  logic        data_ena, data_wea;
  logic [7:0]  data_addr;
  logic [31:0] data_din, data_dout;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  bit          mon_en = 1'b0;

  logic [21:0] tag_mem[64];
  logic [31:0] data_mem[256];

  always #5 clka = ~clka;

  icache_refill_ctrl dut (
    .clka          (clka),
    .rsta_n        (rsta_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_data  (cpu_rsp_data),
    .flush         (flush),
    .tag_ena       (tag_ena),
    .tag_wea       (tag_wea),
    .tag_addr      (tag_addr),
    .tag_din       (tag_din),
    .tag_dout      (tag_dout),
    .data_ena      (data_ena),
    .data_wea      (data_wea),
    .data_addr     (data_addr),
    .data_din      (data_din),
    .data_dout     (data_dout),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  // Macro models: registered read, douta returns 0 after a disabled cycle.
  always @(posedge clka) begin
    if (tag_ena) begin
      if (tag_wea) tag_mem[tag_addr] <= tag_din;
      tag_dout <= tag_wea ? 22'd0 : tag_mem[tag_addr];
    end else begin
      tag_dout <= 22'd0;
    end
    if (data_ena) begin
      if (data_wea) data_mem[data_addr] <= data_din;
      data_dout <= data_wea ? 32'd0 : data_mem[data_addr];
    end else begin
      data_dout <= 32'd0;
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
  endfunction

  always @(negedge clka) begin
    if (mon_en) begin
      if (cpu_rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got data %h, expected no response", cpu_rsp_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cpu_rsp_data !== mon_exp) begin
            errors++;
            $display("FAIL rsp_data: got %h expected %h", cpu_rsp_data, mon_exp);
          end
        end
      end else begin
        checks++;
        if (cpu_rsp_data !== 32'd0) begin
          errors++;
          $display("FAIL rsp_data_idle: got %h expected 0", cpu_rsp_data);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input bit exp_hit, input string name);
    int n = 0;
    do begin
      @(negedge clka); #1;
      n++;
    end while (cpu_req_ready !== 1'b1 && n < 10);
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b expected 1", name, cpu_req_ready);
      return;
    end
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    exp_q.push_back(mem_word(a));
    #1;
    checks++;
    if ({tag_ena, data_ena, tag_addr, data_addr} !== {1'b1, 1'b1, a[9:4], a[9:2]}) begin
      errors++;
      $display("FAIL %s lookup_addr: got %b %b %h %h expected 1 1 %h %h", name, tag_ena,
               data_ena, tag_addr, data_addr, a[9:4], a[9:2]);
    end
    @(negedge clka);
    cpu_req_valid = 1'b0;
    cpu_req_addr  = 32'd0;
    #1;
    checks++;
    if ({cpu_rsp_valid, cpu_req_ready, mem_req_valid} !== {exp_hit, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s lookup: got rsp/ready/memreq %b%b%b expected %b00", name, cpu_rsp_valid,
               cpu_req_ready, mem_req_valid, exp_hit);
    end
  endtask

  task automatic refill(input logic [31:0] a, input int stall, input int flush_beat,
                        input int abort_beat, input string name);
    logic [31:0] line;
    int n = 0;
    line = {a[31:4], 4'h0};
    do begin
      @(negedge clka); #1;
      n++;
    end while (mem_req_valid !== 1'b1 && n < 10);
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) mem_req_ready = 1'b1;
      checks++;
      if ({mem_req_valid, mem_req_addr} !== {1'b1, line}) begin
        errors++;
        $display("FAIL %s mem_req: got %b %h expected 1 %h", name, mem_req_valid, mem_req_addr,
                 line);
        mem_req_ready = 1'b0;
        return;
      end
      @(negedge clka);
      if (i < stall) #1;
    end
    mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(line + 32'(4 * b));
      flush         = (b == flush_beat);
      #1;
      if (b == abort_beat) begin
        rsta_n = 1'b0;
        #1;
        checks++;
        if (cpu_req_ready !== 1'b1 || {cpu_rsp_valid, cpu_rsp_data, mem_req_valid, mem_req_addr,
            tag_ena, tag_wea, tag_addr, tag_din, data_ena, data_wea, data_addr, data_din} !== '0)
        begin
          errors++;
          $display("FAIL %s reset_outputs: ready=%b data_ena=%b data_wea=%b memreq=%b expected 1 0 0 0",
                   name, cpu_req_ready, data_ena, data_wea, mem_req_valid);
        end
        void'(exp_q.pop_back());
        @(negedge clka);
        rsta_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = 32'hBAD0_0000 + 32'(s);
          #1;
          checks++;
          if ({data_ena, data_wea, tag_ena, tag_wea} !== 4'b0000) begin
            errors++;
            $display("FAIL %s stray_beat%0d: got ena/wea %b%b%b%b expected 0000", name, s,
                     data_ena, data_wea, tag_ena, tag_wea);
          end
          @(negedge clka);
        end
        mem_rsp_valid = 1'b0;
        return;
      end
      checks++;
      if ({data_ena, data_wea, data_addr, data_din} !==
          {2'b11, a[9:4], 2'(b), mem_word(line + 32'(4 * b))}) begin
        errors++;
        $display("FAIL %s beat%0d: got %b%b %h %h expected 11 %h %h", name, b, data_ena, data_wea,
                 data_addr, data_din, {a[9:4], 2'(b)}, mem_word(line + 32'(4 * b)));
      end
      if (b == 3) begin
        checks++;
        if ({tag_ena, tag_wea, tag_addr, tag_din} !== {2'b11, a[9:4], a[31:10]}) begin
          errors++;
          $display("FAIL %s tag_write: got %b%b %h %h expected 11 %h %h", name, tag_ena, tag_wea,
                   tag_addr, tag_din, a[9:4], a[31:10]);
        end
      end
      @(negedge clka);
    end
    mem_rsp_valid = 1'b0;
    flush         = 1'b0;
    #1;
    checks++;
    if (cpu_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s respond: got rsp_valid %b expected 1", name, cpu_rsp_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (cpu_req_ready !== 1'b1 || {cpu_rsp_valid, cpu_rsp_data, mem_req_valid, mem_req_addr,
        tag_ena, tag_wea, data_ena, data_wea} !== '0) begin
      errors++;
      $display("FAIL reset: got ready=%b rsp=%b memreq=%b tag_ena=%b data_ena=%b expected 1 0 0 0 0",
               cpu_req_ready, cpu_rsp_valid, mem_req_valid, tag_ena, data_ena);
    end
`ifdef ICACHE_STATS_EN
    checks++;
    if ({hit_count, miss_count} !== 64'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d %0d expected 0 0", hit_count, miss_count);
    end
`endif
    @(negedge clka);
    rsta_n = 1'b1;
  endtask

  task automatic test_miss_refill();
    issue(32'h100, 1'b0, "t1_miss");
    refill(32'h100, 0, -1, -1, "t1_refill");
  endtask

  task automatic test_hit();
    issue(32'h104, 1'b1, "t2_hit");
    @(negedge clka); #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL t2_no_memreq: got %b expected 0", mem_req_valid);
    end
  endtask

  task automatic test_conflict();
    issue(32'h1100, 1'b0, "t3_conflict");
    refill(32'h1100, 0, -1, -1, "t3_refill");
    issue(32'h100, 1'b0, "t3_evicted");
    refill(32'h100, 0, -1, -1, "t3_refill_back");
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    @(negedge clka); #1;
    checks++;
    if ({hit_count, miss_count} !== {32'd1, 32'd3}) begin
      errors++;
      $display("FAIL stats: got hit %0d miss %0d expected 1 3", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_flush_idle();
    @(negedge clka);
    flush         = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h104;
    #1;
    checks++;
    if ({cpu_req_ready, tag_ena} !== 2'b00) begin
      errors++;
      $display("FAIL t4_flush_ready: got ready/tag_ena %b%b expected 00", cpu_req_ready, tag_ena);
    end
    @(negedge clka);
    flush         = 1'b0;
    cpu_req_valid = 1'b0;
    #1;
    checks++;
    if ({cpu_req_ready, cpu_rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL t4_after_flush: got ready/rsp %b%b expected 10", cpu_req_ready, cpu_rsp_valid);
    end
    issue(32'h108, 1'b0, "t4_miss");
    refill(32'h108, 0, -1, -1, "t4_refill");
  endtask

  task automatic test_back_to_back();
    issue(32'h100, 1'b1, "b2b_0");
    issue(32'h104, 1'b1, "b2b_1");
    issue(32'h10C, 1'b1, "b2b_3");
  endtask

  task automatic test_reset_mid_refill();
    issue(32'h200, 1'b0, "t5_miss");
    refill(32'h200, 0, -1, 2, "t5_abort");
    issue(32'h100, 1'b0, "t5_after_reset");
    refill(32'h100, 0, -1, -1, "t5_refill");
  endtask

  task automatic test_req_stall();
    issue(32'h308, 1'b0, "t6_miss");
    refill(32'h308, 5, -1, -1, "t6_stall");
  endtask

  task automatic test_flush_pending();
    issue(32'h404, 1'b0, "fp_miss");
    refill(32'h404, 0, 1, -1, "fp_refill");
    @(negedge clka); #1;
    checks++;
    if (cpu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fp_ready_low: got %b expected 0", cpu_req_ready);
    end
    @(negedge clka); #1;
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fp_ready_back: got %b expected 1", cpu_req_ready);
    end
    issue(32'h404, 1'b0, "fp_invalidated");
    refill(32'h404, 0, -1, -1, "fp_refill2");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tag_mem[i] = 22'd0;
    for (int i = 0; i < 256; i++) data_mem[i] = 32'd0;
    tag_dout      = 22'd0;
    data_dout     = 32'd0;
    rsta_n        = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = 32'd0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    repeat (2) @(negedge clka);
    test_reset();
    mon_en = 1'b1;
    test_miss_refill();
    test_hit();
    test_conflict();
    test_stats();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid_refill();
    test_req_stall();
    test_flush_pending();
    repeat (3) @(negedge clka);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_rsp: got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
